// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for a Sobel engine: builds 3x3 windows from a raster pixel stream,
// issues one window at a time and tags each returned gradient with its centre (x,y).
module sobel_frame_ctrl #(
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     pix_valid,
  input  logic [7:0]               pix_data,
  output logic                     pix_ready,
  output logic                     eng_enable,
  output logic                     eng_valid_in,
  output logic [71:0]              eng_pixels,
  input  logic                     eng_busy,
  input  logic                     eng_valid_out,
  input  logic [15:0]              eng_gradient,
  output logic                     res_valid,
  output logic [15:0]              res_data,
  output logic [$clog2(IMG_W)-1:0] res_x,
  output logic [$clog2(IMG_H)-1:0] res_y,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err_timeout
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [7:0]       r_lb0 [IMG_W];
  logic [7:0]       r_lb1 [IMG_W];
  logic [7:0]       r_win [3][3];

  logic [71:0]      r_eng_pixels;
  logic             r_eng_valid_in;
  logic             r_eng_enable;
  logic             r_res_valid;
  logic [15:0]      r_res_data;
  logic [COL_W-1:0] r_res_x;
  logic [ROW_W-1:0] r_res_y;
  logic             r_frame_done;
  logic             r_err_timeout;

  logic             w_pix_ready;
  logic             w_start_frame;
  logic             w_accept;
  logic             w_issue;
  logic             w_result;
  logic             w_timeout;
  logic             w_advance;
  logic             w_win_ready;
  logic             w_last_pix;
  logic             w_tmo_last;
  logic [71:0]      w_window;

  // A window is complete once the current pixel is at least the third row and third column.
  assign w_win_ready = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
  assign w_last_pix  = (r_col == COL_W'(IMG_W - 1)) && (r_row == ROW_W'(IMG_H - 1));
  assign w_tmo_last  = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign w_window    = {r_win[0][0], r_win[0][1], r_win[0][2],
                        r_win[1][0], r_win[1][1], r_win[1][2],
                        r_win[2][0], r_win[2][1], r_win[2][2]};

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal gets its default before the case, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_pix_ready   = 1'b0;
    w_start_frame = 1'b0;
    w_accept      = 1'b0;
    w_issue       = 1'b0;
    w_result      = 1'b0;
    w_timeout     = 1'b0;
    w_advance     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_frame = 1'b1;
          w_state_nxt   = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        w_pix_ready = 1'b1;
        if (pix_valid) begin
          w_accept = 1'b1;
          if (w_win_ready) w_state_nxt = S_ISSUE;
          else             w_advance   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!eng_busy) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_valid_out) begin
          w_result    = 1'b1;
          w_advance   = 1'b1;
          w_state_nxt = w_last_pix ? S_DONE : S_ACCEPT;
        end else if (w_tmo_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the line buffers sit in the async reset so a reset frame starts from all-zero storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        r_lb0[i] <= '0;
        r_lb1[i] <= '0;
      end
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_win[r][c] <= '0;
    end else if (w_accept) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2]  <= r_lb1[r_col];
      r_win[1][2]  <= r_lb0[r_col];
      r_win[2][2]  <= pix_data;
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col          <= '0;
      r_row          <= '0;
      r_tmo_cnt      <= '0;
      r_eng_pixels   <= '0;
      r_eng_valid_in <= 1'b0;
      r_eng_enable   <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_res_x        <= '0;
      r_res_y        <= '0;
      r_frame_done   <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_eng_valid_in <= 1'b0;
      r_res_valid    <= 1'b0;
      r_frame_done   <= (r_state == S_DONE);

      if (w_start_frame) begin
        r_err_timeout <= 1'b0;
        r_eng_enable  <= 1'b1;
      end
      if (r_state == S_DONE) r_eng_enable <= 1'b0;

      if (w_start_frame) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_advance) begin
        if (r_col == COL_W'(IMG_W - 1)) begin
          r_col <= '0;
          r_row <= r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end

      // The window snapshot is held on eng_pixels until the next issue.
      if (w_issue) begin
        r_eng_valid_in <= 1'b1;
        r_eng_pixels   <= w_window;
        r_tmo_cnt      <= '0;
      end else if (r_state == S_WAIT) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end

      if (w_result) begin
        r_res_valid <= 1'b1;
        r_res_data  <= eng_gradient;
        r_res_x     <= r_col - COL_W'(1);
        r_res_y     <= r_row - ROW_W'(1);
      end
      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign pix_ready    = w_pix_ready;
  assign busy         = (r_state != S_IDLE);
  assign eng_enable   = r_eng_enable;
  assign eng_valid_in = r_eng_valid_in;
  assign eng_pixels   = r_eng_pixels;
  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign res_x        = r_res_x;
  assign res_y        = r_res_y;
  assign frame_done   = r_frame_done;
  assign err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: a 3x3 and a 5x4 instance, each with a pixel source, a
// latency-2 engine model and a result monitor, compared against a per-frame window model.
module tb_sobel_frame_ctrl;
  localparam int TMO = 32;
  localparam int W0 = 3, H0 = 3, W1 = 5, H1 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start        [2] = '{1'b0, 1'b0};
  logic        pix_valid    [2] = '{1'b0, 1'b0};
  logic [7:0]  pix_data     [2] = '{8'd0, 8'd0};
  logic        eng_busy     [2] = '{1'b0, 1'b0};
  logic        eng_valid_out[2] = '{1'b0, 1'b0};
  logic [15:0] eng_gradient [2] = '{16'd0, 16'd0};
  logic        pix_ready[2], eng_enable[2], eng_valid_in[2], res_valid[2];
  logic        busy[2], frame_done[2], err_timeout[2];
  logic [71:0] eng_pixels[2];
  logic [15:0] res_data[2];
  logic [1:0]  res_x0, res_y0, res_y1;
  logic [2:0]  res_x1;

  sobel_frame_ctrl #(.IMG_W(W0), .IMG_H(H0), .TIMEOUT_CYC(TMO)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .pix_valid(pix_valid[0]), .pix_data(pix_data[0]),
    .pix_ready(pix_ready[0]), .eng_enable(eng_enable[0]), .eng_valid_in(eng_valid_in[0]),
    .eng_pixels(eng_pixels[0]), .eng_busy(eng_busy[0]), .eng_valid_out(eng_valid_out[0]),
    .eng_gradient(eng_gradient[0]), .res_valid(res_valid[0]), .res_data(res_data[0]),
    .res_x(res_x0), .res_y(res_y0), .busy(busy[0]), .frame_done(frame_done[0]),
    .err_timeout(err_timeout[0]));

  sobel_frame_ctrl #(.IMG_W(W1), .IMG_H(H1), .TIMEOUT_CYC(TMO)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .pix_valid(pix_valid[1]), .pix_data(pix_data[1]),
    .pix_ready(pix_ready[1]), .eng_enable(eng_enable[1]), .eng_valid_in(eng_valid_in[1]),
    .eng_pixels(eng_pixels[1]), .eng_busy(eng_busy[1]), .eng_valid_out(eng_valid_out[1]),
    .eng_gradient(eng_gradient[1]), .res_valid(res_valid[1]), .res_data(res_data[1]),
    .res_x(res_x1), .res_y(res_y1), .busy(busy[1]), .frame_done(frame_done[1]),
    .err_timeout(err_timeout[1]));

  // Controls written only by the test sequence
  logic [7:0] img [2][64];
  int  npix[2]       = '{9, 20};
  int  gap_pct[2]    = '{0, 0};
  int  src_frame[2]  = '{0, 0};
  bit  src_en[2]     = '{1'b0, 1'b0};
  bit  force_busy[2] = '{1'b0, 1'b0};
  bit  no_answer[2]  = '{1'b0, 1'b0};

  // State written only by the negedge process
  int  cyc = 0;
  int  src_idx[2] = '{0, 0}, src_seen[2] = '{0, 0}, eng_cnt[2] = '{0, 0};
  bit  src_fire[2] = '{1'b0, 1'b0}, err_prev[2] = '{1'b0, 1'b0};
  logic [71:0] eng_win[2];
  int  res_n[2] = '{0, 0}, win_n[2] = '{0, 0}, fd_n[2] = '{0, 0}, fd_res[2] = '{0, 0};
  int  res_cyc[2] = '{0, 0}, fd_cyc[2] = '{0, 0}, iss_cyc[2] = '{0, 0}, err_cyc[2] = '{0, 0};
  logic [15:0] res_d [2][256];
  int          res_xa[2][256], res_ya[2][256];
  logic [71:0] win_a [2][256];

  // Reference model output for one frame
  int          exp_n;
  logic [15:0] exp_g [64];
  logic [71:0] exp_w [64];
  int          exp_x [64], exp_y [64];

  int n_pass = 0, n_tot = 0;

  function automatic logic [15:0] gx(input logic [71:0] w);
    int p[9];
    for (int i = 0; i < 9; i++) p[i] = int'(w[71-8*i -: 8]);
    return 16'((p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]));
  endfunction

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (res_valid[k]) begin
        res_d[k][res_n[k] % 256]  = res_data[k];
        res_xa[k][res_n[k] % 256] = (k == 0) ? int'(res_x0) : int'(res_x1);
        res_ya[k][res_n[k] % 256] = (k == 0) ? int'(res_y0) : int'(res_y1);
        res_cyc[k] = cyc;
        res_n[k]++;
      end
      if (frame_done[k]) begin
        fd_n[k]++;
        fd_res[k] = res_n[k];
        fd_cyc[k] = cyc;
      end
      if (err_timeout[k] && !err_prev[k]) err_cyc[k] = cyc;
      err_prev[k] = err_timeout[k];

      eng_valid_out[k] = 1'b0;
      if (eng_cnt[k] > 0) begin
        eng_cnt[k]--;
        if (eng_cnt[k] == 0 && !no_answer[k]) begin
          eng_valid_out[k] = 1'b1;
          eng_gradient[k]  = gx(eng_win[k]);
        end
      end
      if (eng_valid_in[k]) begin
        win_a[k][win_n[k] % 256] = eng_pixels[k];
        win_n[k]++;
        iss_cyc[k] = cyc;
        eng_win[k] = eng_pixels[k];
        eng_cnt[k] = 2;
      end
      eng_busy[k] = force_busy[k] || (eng_cnt[k] > 0);

      // pix_ready only moves on posedge, so its value now holds for the coming edge
      if (src_seen[k] != src_frame[k]) begin
        src_seen[k] = src_frame[k];
        src_idx[k]  = 0;
      end else if (src_fire[k]) begin
        src_idx[k]++;
      end
      src_fire[k] = 1'b0;
      if (src_en[k] && src_idx[k] < npix[k] && int'($urandom_range(99)) >= gap_pct[k]) begin
        pix_valid[k] = 1'b1;
        pix_data[k]  = img[k][src_idx[k]];
        src_fire[k]  = pix_ready[k];
      end else begin
        pix_valid[k] = 1'b0;
        pix_data[k]  = 8'($urandom);
      end
    end
  end

  function automatic void build_model(input int k, input int w, input int h);
    exp_n = 0;
    for (int y = 1; y <= h - 2; y++) begin
      for (int x = 1; x <= w - 2; x++) begin
        logic [71:0] win;
        int right, left;
        win = '0;
        for (int r = -1; r <= 1; r++)
          for (int c = -1; c <= 1; c++)
            win = {win[63:0], img[k][(y+r)*w + (x+c)]};
        right = int'(img[k][(y-1)*w + x+1]) + 2*int'(img[k][y*w + x+1]) + int'(img[k][(y+1)*w + x+1]);
        left  = int'(img[k][(y-1)*w + x-1]) + 2*int'(img[k][y*w + x-1]) + int'(img[k][(y+1)*w + x-1]);
        exp_w[exp_n] = win;
        exp_g[exp_n] = 16'(right - left);
        exp_x[exp_n] = x;
        exp_y[exp_n] = y;
        exp_n++;
      end
    end
  endfunction

  task automatic load_test1();
    for (int i = 0; i < 9; i++) img[0][i] = (i % 3 == 2) ? 8'd255 : 8'd0;
  endtask

  task automatic load_ramp3();
    for (int i = 0; i < 9; i++) img[0][i] = 8'(10 * (i + 1));
  endtask

  task automatic run_frame(input int k, input int gap, input bit poke, input string tag);
    int n;
    n = fd_n[k];
    gap_pct[k] = gap;
    src_frame[k]++;
    src_en[k] = 1'b1;
    @(negedge clk); start[k] = 1'b1;
    @(negedge clk); start[k] = 1'b0;
    for (int c = 0; c < 4000 && fd_n[k] == n; c++) begin
      @(negedge clk);
      start[k] = poke && (c == 12);
    end
    start[k]  = 1'b0;
    src_en[k] = 1'b0;
    n_tot++;
    if (fd_n[k] == n) $display("FAIL %s_done: frame_done count %0d, required %0d", tag, fd_n[k], n + 1);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic verify_frame(input int k, input int w, input int h, input int rb, input int wb,
                              input string tag);
    build_model(k, w, h);
    n_tot++;
    if (res_n[k] - rb !== exp_n) $display("FAIL %s_nres: got %0d results, required %0d", tag, res_n[k] - rb, exp_n);
    else n_pass++;
    n_tot++;
    if (win_n[k] - wb !== exp_n) $display("FAIL %s_nissue: got %0d issues, required %0d", tag, win_n[k] - wb, exp_n);
    else n_pass++;
    for (int i = 0; i < exp_n; i++) begin
      n_tot++;
      if (win_a[k][(wb+i) % 256] !== exp_w[i])
        $display("FAIL %s_win%0d: got %h, required %h", tag, i, win_a[k][(wb+i) % 256], exp_w[i]);
      else n_pass++;
      n_tot++;
      if (res_d[k][(rb+i) % 256] !== exp_g[i])
        $display("FAIL %s_data%0d: got %0d, required %0d", tag, i, res_d[k][(rb+i) % 256], exp_g[i]);
      else n_pass++;
      n_tot++;
      if (res_xa[k][(rb+i) % 256] !== exp_x[i] || res_ya[k][(rb+i) % 256] !== exp_y[i])
        $display("FAIL %s_xy%0d: got (%0d,%0d), required (%0d,%0d)", tag, i,
                 res_xa[k][(rb+i) % 256], res_ya[k][(rb+i) % 256], exp_x[i], exp_y[i]);
      else n_pass++;
    end
    n_tot++;
    if (fd_res[k] - rb !== exp_n) $display("FAIL %s_done_order: frame_done after %0d results, required %0d", tag, fd_res[k] - rb, exp_n);
    else n_pass++;
    n_tot++;
    if ({err_timeout[k], busy[k], eng_enable[k]} !== 3'b000)
      $display("FAIL %s_idle: err/busy/enable=%b, required 000", tag, {err_timeout[k], busy[k], eng_enable[k]});
    else n_pass++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      n_tot++;
      if ({pix_ready[k], eng_enable[k], eng_valid_in[k], eng_pixels[k], res_valid[k], res_data[k],
           busy[k], frame_done[k], err_timeout[k]} !== '0)
        $display("FAIL reset_outputs%0d: some output nonzero during reset", k);
      else n_pass++;
    end
    n_tot++;
    if ({res_x0, res_y0, res_x1, res_y1} !== '0) $display("FAIL reset_xy: got %h, required 0", {res_x0, res_y0, res_x1, res_y1});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tot++;
    if ({busy[0], busy[1], pix_ready[0], pix_ready[1]} !== 4'b0) $display("FAIL reset_idle: busy/ready=%b, required 0000", {busy[0], busy[1], pix_ready[0], pix_ready[1]});
    else n_pass++;
  endtask

  task automatic test_single_window();
    int rb, wb;
    logic [71:0] want;
    want = 72'h0000FF0000FF0000FF;
    load_test1();
    rb = res_n[0]; wb = win_n[0];
    run_frame(0, 0, 1'b0, "t1");
    verify_frame(0, W0, H0, rb, wb, "t1");
    n_tot++;
    if (win_a[0][wb % 256] !== want) $display("FAIL t1_pixels: got %h, required %h", win_a[0][wb % 256], want);
    else n_pass++;
    n_tot++;
    if (fd_cyc[0] - res_cyc[0] !== 1) $display("FAIL t1_done_lag: frame_done %0d cycles after res_valid, required 1", fd_cyc[0] - res_cyc[0]);
    else n_pass++;
  endtask

  task automatic test_ramp();
    int rb, wb;
    load_ramp3();
    rb = res_n[0]; wb = win_n[0];
    run_frame(0, 0, 1'b0, "t2");
    verify_frame(0, W0, H0, rb, wb, "t2");
  endtask

  task automatic test_gaps();
    int rb, wb;
    for (int y = 0; y < H1; y++)
      for (int x = 0; x < W1; x++) img[1][y*W1 + x] = 8'(x + 10*y);
    rb = res_n[1]; wb = win_n[1];
    run_frame(1, 40, 1'b0, "t3");
    verify_frame(1, W1, H1, rb, wb, "t3");
  endtask

  task automatic test_timeout();
    int rb, wb;
    load_test1();
    no_answer[0] = 1'b1;
    rb = res_n[0];
    run_frame(0, 0, 1'b0, "t4");
    n_tot++;
    if (err_timeout[0] !== 1'b1) $display("FAIL t4_err: err_timeout=%b, required 1", err_timeout[0]);
    else n_pass++;
    n_tot++;
    if (err_cyc[0] - iss_cyc[0] !== TMO) $display("FAIL t4_latency: timeout after %0d cycles, required %0d", err_cyc[0] - iss_cyc[0], TMO);
    else n_pass++;
    n_tot++;
    if (res_n[0] !== rb) $display("FAIL t4_nores: got %0d results, required %0d", res_n[0] - rb, 0);
    else n_pass++;
    n_tot++;
    if ({busy[0], eng_enable[0]} !== 2'b00) $display("FAIL t4_idle: busy/enable=%b, required 00", {busy[0], eng_enable[0]});
    else n_pass++;
    no_answer[0] = 1'b0;
    load_ramp3();
    rb = res_n[0]; wb = win_n[0];
    run_frame(0, 0, 1'b0, "t4r");
    verify_frame(0, W0, H0, rb, wb, "t4r");
  endtask

  task automatic test_busy_stall();
    int rb, wb, bad, c;
    load_ramp3();
    force_busy[0] = 1'b1;
    rb = res_n[0]; wb = win_n[0];
    src_frame[0]++;
    gap_pct[0] = 0;
    src_en[0] = 1'b1;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (c = 0; c < 200 && src_idx[0] < 9; c++) @(negedge clk);
    n_tot++;
    if (src_idx[0] < 9) $display("FAIL t5_accept: accepted %0d pixels, required 9", src_idx[0]);
    else n_pass++;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (eng_valid_in[0] || pix_ready[0] || !busy[0]) bad++;
    end
    n_tot++;
    if (bad !== 0 || win_n[0] !== wb) $display("FAIL t5_stall: %0d bad cycles, %0d issues, required 0 and 0", bad, win_n[0] - wb);
    else n_pass++;
    force_busy[0] = 1'b0;
    for (c = 0; c < 200 && fd_n[0] == 0; c++) @(negedge clk);
    for (c = 0; c < 200 && busy[0]; c++) @(negedge clk);
    src_en[0] = 1'b0;
    repeat (2) @(negedge clk);
    verify_frame(0, W0, H0, rb, wb, "t5");
  endtask

  task automatic test_midframe_reset();
    int fdb, rb, wb, c;
    load_test1();
    fdb = fd_n[0];
    src_frame[0]++;
    gap_pct[0] = 0;
    src_en[0] = 1'b1;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (c = 0; c < 200 && src_idx[0] < 5; c++) @(negedge clk);
    rst_n = 1'b0;
    src_en[0] = 1'b0;
    #1;
    n_tot++;
    if ({pix_ready[0], eng_enable[0], eng_valid_in[0], eng_pixels[0], res_valid[0], res_data[0],
         res_x0, res_y0, busy[0], frame_done[0], err_timeout[0]} !== '0)
      $display("FAIL t6_reset_outputs: some output nonzero right after rst_n fell");
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tot++;
    if (fd_n[0] !== fdb) $display("FAIL t6_no_done: got %0d frame_done pulses, required 0", fd_n[0] - fdb);
    else n_pass++;
    rb = res_n[0]; wb = win_n[0];
    run_frame(0, 0, 1'b0, "t6");
    verify_frame(0, W0, H0, rb, wb, "t6");
  endtask

  task automatic test_random();
    int rb, wb;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < W1*H1; i++) img[1][i] = 8'($urandom);
      rb = res_n[1]; wb = win_n[1];
      run_frame(1, int'($urandom_range(60)), f == 1, "rnd");
      verify_frame(1, W1, H1, rb, wb, "rnd");
    end
    for (int i = 0; i < 9; i++) img[0][i] = 8'($urandom);
    rb = res_n[0]; wb = win_n[0];
    run_frame(0, 50, 1'b1, "rnd3");
    verify_frame(0, W0, H0, rb, wb, "rnd3");
  endtask

  task automatic test_back_to_back();
    int rb, wb;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W1*H1; i++) img[1][i] = 8'($urandom);
      rb = res_n[1]; wb = win_n[1];
      run_frame(1, 0, 1'b0, "b2b");
      verify_frame(1, W1, H1, rb, wb, "b2b");
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_single_window();
    test_ramp();
    test_gaps();
    test_timeout();
    test_busy_stall();
    test_midframe_reset();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
